core_mem_wb: RTL
================

CORE_MEM_WB -- requirements
Module: core_mem_wb

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 mem_valid  input  1  MEM stage holds a real instruction (0 = bubble).
REQ-004 mem_rf_write  input  1  instruction writes a register.
REQ-005 mem_waddr  input  5  destination register index.
REQ-006 mem_alu_result  input  32  ALU/address result from EX/MEM.
REQ-007 mem_load_data  input  32  raw word returned by data memory.
REQ-008 mem_to_reg  input  1  1 = write load data, 0 = write mem_alu_result.
REQ-009 mem_ld_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 mem_ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend sub-word loads.
REQ-011 mem_addr_lo  input  2  load address bits [1:0].
REQ-012 stall  input  1  hold WB register contents.
REQ-013 flush  input  1  replace incoming instruction with a bubble.
REQ-014 rf_write  output  1  register-file write enable (drives regfile rf_write).
REQ-015 waddr  output  5  register-file write index (drives regfile waddr).
REQ-016 data  output  32  register-file write data (drives regfile data).
REQ-017 wb_valid  output  1  WB stage holds a real instruction.
REQ-018 retired  output  32  count of instructions that entered WB.

Function
REQ-019 Block SHALL be a single pipeline register: inputs sampled on rising clk appear on outputs the same edge; latency exactly 1 cycle, no combinational input-to-output path.
REQ-020 data SHALL be computed before the register (registered output): mem_to_reg=0 -> mem_alu_result; mem_to_reg=1 -> aligned load value.
REQ-021 Byte load SHALL select mem_load_data[8*mem_addr_lo+7 : 8*mem_addr_lo], extend to 32 bits per mem_ld_unsigned.
REQ-022 Half load SHALL select bits [31:16] when mem_addr_lo[1]=1 else [15:0]; mem_addr_lo[0] ignored (no misalign trap); extend per mem_ld_unsigned.
REQ-023 Word load and reserved size 11 SHALL pass mem_load_data unchanged; mem_ld_unsigned and mem_addr_lo ignored.
REQ-024 rf_write SHALL register as mem_valid & mem_rf_write & (mem_waddr != 0); writes to r0 always suppressed, waddr/data still registered.
REQ-025 stall=1, flush=0: all registers incl. retired SHALL hold; held rf_write repeats identical write (idempotent).
REQ-026 flush=1 (regardless of stall): next edge SHALL load bubble: wb_valid=0, rf_write=0, waddr/data/retired unchanged.
REQ-027 retired SHALL increment by 1 on each edge that loads mem_valid=1 (not stalled, not flushed); wraps 0xFFFFFFFF -> 0x00000000.
REQ-028 Bubble (mem_valid=0, no stall) SHALL load wb_valid=0, rf_write=0; waddr/data load inputs (don't-care to consumer).

Reset
REQ-029 rst=1 SHALL immediately, without clk, force rf_write=0, waddr=0, data=0, wb_valid=0, retired=0.
REQ-030 rst asserted mid-stall or mid-flush SHALL override both; first edge after rst falls resumes normal sampling.

Verification
REQ-031 ALU write: mem_valid=1, mem_rf_write=1, waddr=5, to_reg=0, alu=0x12345678 -> next edge rf_write=1, waddr=5, data=0x12345678, retired=1.
REQ-032 Byte loads: load_data=0x80FF7F01, size=00, addr_lo=0..3, signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; unsigned addr_lo=3 -> 0x00000080.
REQ-033 Half loads: load_data=0x8001F00F, size=01, signed addr_lo=2 -> 0xFFFF8001; unsigned addr_lo=0 -> 0x0000F00F; addr_lo=1 -> same as addr_lo=0.
REQ-034 r0 suppression: valid write to waddr=0, data 0xDEADBEEF -> rf_write=0, wb_valid=1, retired increments.
REQ-035 Stall/flush: stall=1 for 3 cycles with new inputs -> outputs and retired frozen; stall=1 & flush=1 -> next edge wb_valid=0, rf_write=0, retired unchanged.
REQ-036 Wrap and async reset: preload retired=0xFFFFFFFF via valid stream -> next valid gives 0; assert rst between edges -> all outputs 0 before next clk.

Source files
------------

// File: rtl/core_mem_wb.sv
// MEM/WB pipeline register: aligns and extends load data, then registers the
// register-file write request and keeps a count of retired instructions.
module core_mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_rf_write,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic        mem_to_reg,
  input  logic [1:0]  mem_ld_size,
  input  logic        mem_ld_unsigned,
  input  logic [1:0]  mem_addr_lo,
  input  logic        stall,
  input  logic        flush,
  output logic        rf_write,
  output logic [4:0]  waddr,
  output logic [31:0] data,
  output logic        wb_valid,
  output logic [31:0] retired
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic [31:0] data_next;
  logic        rf_write_next;

  always_comb begin
    byte_sel = mem_load_data[7:0];
    case (mem_addr_lo)
      2'd0: byte_sel = mem_load_data[7:0];
      2'd1: byte_sel = mem_load_data[15:8];
      2'd2: byte_sel = mem_load_data[23:16];
      2'd3: byte_sel = mem_load_data[31:24];
      default: byte_sel = mem_load_data[7:0];
    endcase
    // Halfword selection uses only addr bit 1; misaligned halves are not trapped.
    half_sel = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];

    load_value = mem_load_data;
    case (mem_ld_size)
      2'b00: load_value = {{24{~mem_ld_unsigned & byte_sel[7]}}, byte_sel};
      2'b01: load_value = {{16{~mem_ld_unsigned & half_sel[15]}}, half_sel};
      default: load_value = mem_load_data;
    endcase

    data_next     = mem_to_reg ? load_value : mem_alu_result;
    rf_write_next = mem_valid & mem_rf_write & (mem_waddr != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write <= 1'b0;
      waddr    <= 5'd0;
      data     <= 32'd0;
      wb_valid <= 1'b0;
      retired  <= 32'd0;
    end else if (flush) begin
      // Flush beats stall: inject a bubble but keep the last write index/data.
      rf_write <= 1'b0;
      wb_valid <= 1'b0;
    end else if (!stall) begin
      rf_write <= rf_write_next;
      waddr    <= mem_waddr;
      data     <= data_next;
      wb_valid <= mem_valid;
      if (mem_valid) retired <= retired + 32'd1;
    end
  end

endmodule
